// File: rtl/window_pkg.sv
// Shared types and constants for the windowed min/max tracker.
package window_pkg;

    // Width of the magnitude comparator the tracker is built around.
    localparam int CMP_W     = 4;
    // Count fields are sized for the largest legal window (255).
    localparam int REC_CNT_W = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CMP_W-1:0]     min_val;
        logic [CMP_W-1:0]     max_val;
        logic [REC_CNT_W-1:0] eq_cnt;
        logic [REC_CNT_W-1:0] gt_cnt;
    } result_t;

endpackage

// File: rtl/magnitude_cmp4.sv
// 4-bit unsigned magnitude comparator: a<b, a>b, a==b.
module magnitude_cmp4
    import window_pkg::*;
(
    input  logic [CMP_W-1:0] i_a,
    input  logic [CMP_W-1:0] i_b,
    output logic             o_lt,
    output logic             o_gt,
    output logic             o_eq
);

    // Purely combinational compare; exactly one output is high.
    always_comb begin
        o_lt = (i_a < i_b);
        o_gt = (i_a > i_b);
        o_eq = (i_a == i_b);
    end

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks min, max, and counts equal-to / greater-than the first sample over a
// window of WINDOW accepted samples, then presents one registered record.
//
// Handshakes: a sample moves when in_valid && in_ready on a rising edge; the
// record moves when out_valid && out_ready. in_ready never depends on in_valid,
// and out_valid, once high, stays high with a stable record until it moves
// (or clear/reset drops it).
module window_minmax_tracker
    import window_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int WINDOW = 8,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_eq_cnt,
    output logic [CNT_W-1:0] out_gt_cnt,
    output logic             o_dbg_state
);

    if (WIDTH != CMP_W) begin : g_bad_width
        $error("window_minmax_tracker: WIDTH must equal the comparator width (4)");
    end
    if (WINDOW < 2 || WINDOW > 255) begin : g_bad_window
        $error("window_minmax_tracker: WINDOW must be in 2..255");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_eq;
    logic [CNT_W-1:0] r_gt;
    result_t          r_rec;

    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic             w_min_lt, w_min_gt, w_min_eq;
    logic             w_max_lt, w_max_gt, w_max_eq;
    logic             w_ref_lt, w_ref_gt, w_ref_eq;
    logic [WIDTH-1:0] w_min_nxt;
    logic [WIDTH-1:0] w_max_nxt;
    logic [CNT_W-1:0] w_eq_nxt;
    logic [CNT_W-1:0] w_gt_nxt;
    logic             w_unused_bits;

    magnitude_cmp4 u_cmp_min (
        .i_a (in_data),
        .i_b (r_min),
        .o_lt(w_min_lt),
        .o_gt(w_min_gt),
        .o_eq(w_min_eq)
    );

    magnitude_cmp4 u_cmp_max (
        .i_a (in_data),
        .i_b (r_max),
        .o_lt(w_max_lt),
        .o_gt(w_max_gt),
        .o_eq(w_max_eq)
    );

    magnitude_cmp4 u_cmp_ref (
        .i_a (in_data),
        .i_b (r_ref),
        .o_lt(w_ref_lt),
        .o_gt(w_ref_gt),
        .o_eq(w_ref_eq)
    );

    // Handshake decode and next working values including the current sample.
    always_comb begin
        in_ready  = (r_state == ACCUM) && !clear;
        out_valid = (r_state == HOLD);
        w_accept  = in_valid && in_ready;
        w_first   = (r_count == '0);
        w_last    = (r_count == LAST_IDX);
        w_min_nxt = w_min_lt ? in_data : r_min;
        w_max_nxt = w_max_gt ? in_data : r_max;
        w_eq_nxt  = r_eq + CNT_W'(w_ref_eq);
        w_gt_nxt  = r_gt + CNT_W'(w_ref_gt);
    end

    // FSM and accepted-sample counter; clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_count <= '0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_count <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Working accumulators; the first sample of a window reseeds all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_min <= '0;
            r_max <= '0;
            r_eq  <= '0;
            r_gt  <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_ref <= in_data;
                r_min <= in_data;
                r_max <= in_data;
                r_eq  <= CNT_W'(1);
                r_gt  <= '0;
            end else begin
                r_min <= w_min_nxt;
                r_max <= w_max_nxt;
                r_eq  <= w_eq_nxt;
                r_gt  <= w_gt_nxt;
            end
        end
    end

    // Result record loads on the window's last accept and is held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec <= '0;
        end else if (w_accept && w_last) begin
            r_rec <= '{
                min_val: w_min_nxt,
                max_val: w_max_nxt,
                eq_cnt:  REC_CNT_W'(w_eq_nxt),
                gt_cnt:  REC_CNT_W'(w_gt_nxt)
            };
        end
    end

    // Drive the record and state observation outputs.
    always_comb begin
        out_min       = r_rec.min_val;
        out_max       = r_rec.max_val;
        out_eq_cnt    = CNT_W'(r_rec.eq_cnt);
        out_gt_cnt    = CNT_W'(r_rec.gt_cnt);
        o_dbg_state   = r_state;
        w_unused_bits = ^{w_min_gt, w_min_eq, w_max_lt, w_max_eq, w_ref_lt,
                          r_rec.eq_cnt, r_rec.gt_cnt};
    end

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Self-checking bench for window_minmax_tracker with WINDOW=4.
module tb_window_minmax_tracker;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_eq_cnt;
    logic [CNT_W-1:0] out_gt_cnt;
    logic             o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a window is just the list of accepted samples.
    logic m_hold = 1'b0;
    int   win_q[$];
    int   e_min = 0, e_max = 0, e_eq = 0, e_gt = 0;

    window_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_min    (out_min),
        .out_max    (out_max),
        .out_eq_cnt (out_eq_cnt),
        .out_gt_cnt (out_gt_cnt),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compute_record();
        e_min = win_q[0];
        e_max = win_q[0];
        e_eq  = 0;
        e_gt  = 0;
        foreach (win_q[i]) begin
            if (win_q[i] < e_min) e_min = win_q[i];
            if (win_q[i] > e_max) e_max = win_q[i];
            if (win_q[i] == win_q[0]) e_eq++;
            if (win_q[i] > win_q[0]) e_gt++;
        end
    endtask

    task automatic model_edge(input logic v, input int d, input logic clr, input logic ordy);
        if (clr) begin
            m_hold = 1'b0;
            win_q.delete();
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                win_q.delete();
            end
        end else if (v) begin
            win_q.push_back(d & 15);
            if (win_q.size() == WINDOW) begin
                compute_record();
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic clr);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_hold && !clr));
        chk({tag, ".state"}, 32'(o_dbg_state), 32'(m_hold));
        chk({tag, ".out_min"}, 32'(out_min), 32'(e_min));
        chk({tag, ".out_max"}, 32'(out_max), 32'(e_max));
        chk({tag, ".out_eq_cnt"}, 32'(out_eq_cnt), 32'(e_eq));
        chk({tag, ".out_gt_cnt"}, 32'(out_gt_cnt), 32'(e_gt));
    endtask

    // One clock: drive, check at the falling edge, advance, update the model.
    task automatic cycle(input string tag, input logic v, input int d,
                         input logic clr, input logic ordy);
        in_valid  = v;
        in_data   = WIDTH'(d);
        clear     = clr;
        out_ready = ordy;
        @(negedge clk);
        check_outputs(tag, clr);
        @(posedge clk);
        model_edge(v, d, clr, ordy);
        #1;
    endtask

    task automatic feed4(input string tag, input int a, input int b, input int c, input int d);
        cycle(tag, 1'b1, a, 1'b0, 1'b1);
        cycle(tag, 1'b1, b, 1'b0, 1'b1);
        cycle(tag, 1'b1, c, 1'b0, 1'b1);
        cycle(tag, 1'b1, d, 1'b0, 1'b1);
    endtask

    // Fixed expectations straight from the worked examples.
    task automatic expect_rec(input string tag, input int mn, input int mx, input int eq, input int gt);
        chk({tag, ".fixed_min"}, 32'(out_min), 32'(mn));
        chk({tag, ".fixed_max"}, 32'(out_max), 32'(mx));
        chk({tag, ".fixed_eq"}, 32'(out_eq_cnt), 32'(eq));
        chk({tag, ".fixed_gt"}, 32'(out_gt_cnt), 32'(gt));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".rst_min"}, 32'(out_min), 32'd0);
        chk({tag, ".rst_max"}, 32'(out_max), 32'd0);
        chk({tag, ".rst_eq"}, 32'(out_eq_cnt), 32'd0);
        chk({tag, ".rst_gt"}, 32'(out_gt_cnt), 32'd0);
        chk({tag, ".rst_state"}, 32'(o_dbg_state), 32'd0);
        m_hold = 1'b0;
        win_q.delete();
        e_min = 0; e_max = 0; e_eq = 0; e_gt = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        #7;
        chk("por.out_valid", 32'(out_valid), 32'd0);
        chk("por.out_min", 32'(out_min), 32'd0);
        chk("por.out_eq_cnt", 32'(out_eq_cnt), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("idle", 1'b0, 0, 1'b0, 1'b0);

        // Basic window, immediate drain
        feed4("t1", 5, 9, 2, 5);
        cycle("t1.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t1", 2, 9, 2, 1);
        cycle("t1.after", 1'b0, 0, 1'b0, 1'b1);

        // All-equal and extreme values
        feed4("t2a", 7, 7, 7, 7);
        cycle("t2a.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t2a", 7, 7, 4, 0);
        feed4("t2b", 0, 15, 15, 0);
        cycle("t2b.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t2b", 0, 15, 2, 2);

        // Backpressure with ignored input traffic
        feed4("t3", 1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            cycle("t3.stall", 1'b1, $urandom_range(0, 15), 1'b0, 1'b0);
        end
        expect_rec("t3", 1, 4, 1, 3);
        cycle("t3.xfer", 1'b0, 0, 1'b0, 1'b1);
        cycle("t3.after", 1'b0, 0, 1'b0, 1'b0);

        // Bubbles inside a window
        cycle("t4", 1'b1, 3, 1'b0, 1'b1);
        cycle("t4", 1'b0, 9, 1'b0, 1'b1);
        cycle("t4", 1'b0, 0, 1'b0, 1'b1);
        cycle("t4", 1'b1, 12, 1'b0, 1'b1);
        cycle("t4", 1'b0, 15, 1'b0, 1'b1);
        cycle("t4", 1'b1, 1, 1'b0, 1'b1);
        cycle("t4", 1'b1, 4, 1'b0, 1'b1);
        cycle("t4.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t4", 1, 12, 1, 2);

        // clear mid-window, with a sample offered in the clear cycle
        cycle("t5a", 1'b1, 8, 1'b0, 1'b1);
        cycle("t5a", 1'b1, 1, 1'b0, 1'b1);
        cycle("t5a.clear", 1'b1, 0, 1'b1, 1'b1);
        feed4("t5a", 6, 6, 6, 6);
        cycle("t5a.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t5a", 6, 6, 4, 0);

        // clear while holding a record drops it
        feed4("t5b", 9, 9, 10, 9);
        cycle("t5b.clear", 1'b0, 0, 1'b1, 1'b1);
        cycle("t5b.after", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t5b", 9, 10, 3, 1);
        feed4("t5c", 1, 1, 1, 1);
        cycle("t5c.hold", 1'b0, 0, 1'b0, 1'b1);

        // Reset mid-window and mid-hold
        cycle("t6", 1'b1, 11, 1'b0, 1'b1);
        cycle("t6", 1'b1, 13, 1'b0, 1'b1);
        async_reset("t6.win");
        cycle("t6.idle", 1'b0, 0, 1'b0, 1'b0);
        feed4("t6b", 3, 3, 3, 3);
        cycle("t6b.hold", 1'b0, 0, 1'b0, 1'b0);
        async_reset("t6.hold");
        feed4("t6c", 2, 4, 6, 8);
        cycle("t6c.hold", 1'b0, 0, 1'b0, 1'b1);
        expect_rec("t6c", 2, 8, 1, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic v, clr, ordy;
            int   d;
            v    = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(4, 6);
            clr  = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            cycle("rand", v, d, clr, ordy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_minmax_tracker.md
Name: window_minmax_tracker

Overview:
Streaming consumer of 4-bit samples that uses 4-bit magnitude comparator results to track the running minimum, running maximum and order statistics over a fixed window of WINDOW accepted samples. At window end it presents one registered result record on a valid/ready output, then starts the next window. It sits directly downstream of the 4-bit magnitude comparator and instantiates that comparison function three times per sample.

Parameters:
WIDTH, 4, sample width; fixed at 4 to match the comparator; any other value is a synthesis-time error
WINDOW, 8, samples per window; legal range 2..255
CNT_W, $clog2(WINDOW+1), derived width of the count outputs; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of the current window; priority over all other inputs
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  WIDTH  sample, unsigned
out_valid  output  1  result record valid
out_ready  input  1  consumer accepts the record
out_min  output  WIDTH  smallest sample in the window
out_max  output  WIDTH  largest sample in the window
out_eq_cnt  output  CNT_W  number of samples equal to the window's first sample, including the first sample itself
out_gt_cnt  output  CNT_W  number of samples strictly greater than the window's first sample

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on port rst_n.
- Reset (rst_n=0): state=ACCUM, accepted-count=0, out_valid=0, out_min=0, out_max=0, out_eq_cnt=0, out_gt_cnt=0. Internal ref/min/max registers are set to 0.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid && in_ready.
  - First accepted sample of a window: ref=min=max=in_data, eq=1, gt=0, count=1.
  - Each later sample: min updates if in_data<min; max updates if in_data>max; eq increments if in_data==ref; gt increments if in_data>ref.
  - All decisions come from comparator less/greater/equal outputs. Unsigned compares only.
  - When the WINDOW-th sample is accepted, the record registers load the final values, including that sample's contribution. State becomes HOLD on the same edge.
  - out_valid=1 from the next cycle: 1-cycle latency from the last accept to out_valid.
- State HOLD:
  - in_ready=0. out_valid=1.
  - Outputs are stable until the handshake.
  - On out_valid && out_ready: out_valid=0, count=0, state=ACCUM. in_ready=1 in the following cycle; no same-cycle pass-through.
  - Output record registers keep their last values after the handshake and are not cleared.
- in_valid low inside a window: gaps are allowed; state is unchanged.
- clear=1 (any state):
  - Next cycle: ACCUM, count=0, out_valid=0. A sample presented in the same cycle is not accepted, and a pending record is dropped.
  - in_ready is forced to 0 while clear=1.
- Reset asserted mid-window or mid-HOLD: immediate return to the reset values; the partial window is discarded.
- Counter width: eq and gt saturate by construction (they never exceed WINDOW), so there is no wrap-around.

Decomposition:
- Package window_pkg:
  - state enum {ACCUM, HOLD}
  - localparam CMP_W=4
  - result-record struct {min, max, eq_cnt, gt_cnt}
- Natural sub-module: magnitude_cmp4 (4-bit less/greater/equal), instantiated three times: sample vs min, sample vs max, sample vs ref.
- The top-level holds the FSM, the accepted-sample counter and the record registers.

Test Plan:
1. WINDOW=4; samples 5,9,2,5 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; min=2, max=9, eq_cnt=2, gt_cnt=1. in_ready=0 for exactly one cycle, then 1.
2. WINDOW=4; samples 7,7,7,7 -> min=7, max=7, eq_cnt=4, gt_cnt=0. Then samples 0,15,15,0 -> min=0, max=15, eq_cnt=2, gt_cnt=2 (exercises the extremes).
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid stays 1, in_ready stays 0, record unchanged, in_valid stimulus ignored. Raise out_ready -> one transfer, then ACCUM.
4. Bubbles: samples 3,x,x,12,x,1,4 with in_valid low on the x cycles -> record min=1, max=12, eq_cnt=1, gt_cnt=2. Only 4 accepts counted.
5. clear after 2 samples (8,1), then samples 6,6,6,6 -> record min=6, max=6, eq_cnt=4, gt_cnt=0. Also: clear during HOLD -> out_valid drops next cycle and no transfer occurs.
6. rst_n pulsed low asynchronously mid-window and mid-HOLD -> all outputs read 0 while reset is low. The next full window 2,4,6,8 produces min=2, max=8, eq_cnt=1, gt_cnt=3.
